ring_osc_meas_ctrl: RTL and testbench
=====================================

Name: ring_osc_meas_ctrl

Overview:
- Sequences one ring-oscillator delay measurement.
- Drives the ring enable and holds it for a fixed settle time.
- Counts ring rising edges over a programmable gate of clk cycles, then disables the ring and reports a saturating count.
- Sits between the top-level IO wrapper and the AND-gated inverter ring; replaces direct switch control of the ring enable.

Parameters:
- COUNT_W, 16: width of the edge counter and of result_count.
- GATE_W, 16: width of the gate_len input.
- SETTLE_CYC, 4: clk cycles the ring runs before counting starts (startup transient, synchronizer fill).
- SYNC_STAGES, 2: flip-flop stages synchronizing ring_in into the clk domain; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a measurement; honoured only in IDLE.
- abort  input  1  cancels an in-progress measurement.
- gate_len  input  GATE_W  measurement window in clk cycles; sampled when start is accepted.
- ring_in  input  1  asynchronous ring-oscillator tap.
- ring_en  output  1  ring enable, registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result_count is valid from this cycle.
- result_count  output  COUNT_W  last completed count; held until the next completion.
- overflow  output  1  last completed run saturated; updated together with result_count.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; ring_en, busy, done, overflow = 0; result_count = 0; internal counter, gate latch, synchronizer and edge-detect flops = 0. Reset in any state takes effect at the next edge and asserts no done.
- Synchronizer: ring_in passes through SYNC_STAGES flops, then one more flop for edge detect. rise = sync_out & ~sync_prev.
- States: IDLE, SETTLE, MEASURE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 and abort=0 at edge k: latch gate_len (value 0 is treated as 1), clear counter, go to SETTLE.
  - ring_en=1 and busy=1 from cycle k+1.
- SETTLE: lasts exactly SETTLE_CYC cycles. Edges are ignored. Then go to MEASURE.
- MEASURE:
  - Lasts exactly the latched gate length.
  - Each cycle with rise=1 increments the counter.
  - At all-ones the counter holds and the internal overflow flag is set.
  - Then go to DRAIN.
- DRAIN:
  - ring_en=0 from the first DRAIN cycle.
  - Lasts SYNC_STAGES+1 cycles. Edges are not counted.
  - Then go to DONE.
- DONE: one cycle. done=1, result_count <= counter, overflow <= internal flag, busy=1. Then go to IDLE.
- Latency: start accepted at edge k gives done=1 during cycle k+1+SETTLE_CYC+G+SYNC_STAGES+1, where G is the effective gate length. With defaults and G=10, done is high in cycle k+18.
- abort=1 in SETTLE or MEASURE: next state is DRAIN. After DRAIN go directly to IDLE. No done; result_count and overflow are unchanged.
- abort in DRAIN or DONE: ignored.
- abort and start in the same IDLE cycle: abort wins and the block stays in IDLE.
- start while busy: ignored. No queueing.
- Aliasing: only edges spaced at least 2 clk apart are counted reliably. Faster rings alias; the software divides or uses longer chains. The block does not detect aliasing.

Test Plan:
- Reset: hold rst for 3 cycles with ring_in toggling -> ring_en=0, busy=0, done=0, result_count=0, overflow=0 throughout and one cycle after release.
- Nominal: bench drives ring_in with period 8 clk once ring_en=1; gate_len=80, start -> done exactly at k+1+4+80+3; result_count=10; overflow=0; ring_en low from the DRAIN entry cycle.
- Saturation: COUNT_W=4, ring_in period 2 clk, gate_len=64 -> result_count=15, overflow=1. A following run with gate_len=8 and period 8 -> result_count=1, overflow=0.
- gate_len=0: start -> behaves as G=1; done at k+9 with defaults; result_count is 0 or 1 per the ring phase.
- Abort: abort 20 cycles into MEASURE of an 80-cycle run -> ring_en=0 the next cycle, DRAIN for 3 cycles, IDLE, no done, result_count keeps its prior value. Abort and start together in IDLE -> busy stays 0.
- Busy protection and reset mid-run: start pulsed during MEASURE -> ignored, a single done. rst during MEASURE -> IDLE, ring_en=0 next cycle, no done.

Source files
------------

// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator delay measurement sequencer.
// Enables the ring, waits out the startup transient, counts synchronized ring
// rising edges over a gate of clk cycles, drains the synchronizer with the ring
// disabled, then publishes a saturating count.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ring off, waiting for start
// ST_SETTLE  | ring on, edges ignored for SETTLE_CYC cycles
// ST_MEASURE | ring on, counting rises for the latched gate length
// ST_DRAIN   | ring off, SYNC_STAGES+1 cycles so no stale edge is counted
// ST_DONE    | one cycle, publishes count and overflow, pulses done
module ring_osc_meas_ctrl #(
    parameter int COUNT_W     = 16,
    parameter int GATE_W      = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic               ring_in,
    output logic               ring_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] result_count,
    output logic               overflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(1);
    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYC - 1);
    localparam logic [GATE_W-1:0] DRAIN_LOAD  = GATE_W'(SYNC_STAGES);

    state_t               state;
    state_t               state_next;
    logic [GATE_W-1:0]    tmr;
    logic [GATE_W-1:0]    gate_q;
    logic                 aborted;
    logic [COUNT_W-1:0]   cnt;
    logic                 ovf_flag;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 sync_prev;
    logic                 rise;
    logic                 tmr_zero;
    logic                 accept;

    assign tmr_zero = (tmr == '0);
    assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign accept   = (state == ST_IDLE) && start && !abort;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; abort takes priority over the timer expiring.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept) state_next = ST_SETTLE;
            ST_SETTLE:  if (abort) state_next = ST_DRAIN;
                        else if (tmr_zero) state_next = ST_MEASURE;
            ST_MEASURE: if (abort || tmr_zero) state_next = ST_DRAIN;
            ST_DRAIN:   if (tmr_zero) state_next = aborted ? ST_IDLE : ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Bring the asynchronous ring tap into the clk domain and keep one more flop for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ring_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Phase down-counter, gate latch and abort marker; the timer reloads on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr     <= '0;
            gate_q  <= '0;
            aborted <= 1'b0;
        end else begin
            if (accept) gate_q <= (gate_len == '0) ? GATE_ONE : gate_len;
            if (state_next != state) begin
                case (state_next)
                    ST_SETTLE:  tmr <= SETTLE_LOAD;
                    ST_MEASURE: tmr <= gate_q - GATE_ONE;
                    ST_DRAIN:   tmr <= DRAIN_LOAD;
                    default:    tmr <= '0;
                endcase
                if (state_next == ST_DRAIN) aborted <= abort;
            end else if (!tmr_zero) begin
                tmr <= tmr - GATE_ONE;
            end
        end
    end

    // Saturating edge counter, active only during the gate window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else if (state == ST_MEASURE && rise) begin
            if (cnt == '1) ovf_flag <= 1'b1;
            else           cnt      <= cnt + COUNT_W'(1);
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_count <= '0;
            overflow     <= 1'b0;
        end else begin
            ring_en <= (state_next == ST_SETTLE) || (state_next == ST_MEASURE);
            busy    <= (state_next != ST_IDLE);
            done    <= (state_next == ST_DONE);
            if (state_next == ST_DONE) begin
                result_count <= cnt;
                overflow     <= ovf_flag;
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl with a narrow counter so saturation is reachable.
// The reference model counts sampled ring rises inside the gate window from a
// per-edge history of ring_in and derives all timing from the start edge.
module tb_ring_osc_meas_ctrl;

    localparam int CW     = 4;
    localparam int GW     = 16;
    localparam int SETTLE = 4;
    localparam int SYNC   = 2;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int HIST   = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [GW-1:0] gate_len;
    logic          ring_in;
    logic          ring_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] result_count;
    logic          overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ring_mode   = 0;
    int ring_period = 8;
    int exp_res = 0;
    int exp_ovf = 0;
    logic rhist [0:HIST-1];

    ring_osc_meas_ctrl #(
        .COUNT_W(CW), .GATE_W(GW), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_len(gate_len),
        .ring_in(ring_in), .ring_en(ring_en), .busy(busy), .done(done),
        .result_count(result_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record ring_in as sampled at every rising edge; edge index == cyc before increment.
    always @(posedge clk) begin
        if (cyc < HIST) rhist[cyc] = ring_in;
        cyc = cyc + 1;
    end

    // Ring-oscillator stand-in, updated on the falling edge.
    initial begin
        int phase;
        phase   = 0;
        ring_in = 1'b0;
        forever begin
            @(negedge clk);
            case (ring_mode)
                1: begin
                    if (ring_en) begin
                        ring_in = (phase < ring_period / 2);
                        phase   = (phase + 1) % ring_period;
                    end else begin
                        ring_in = 1'b0;
                        phase   = 0;
                    end
                end
                2:       ring_in = 1'($urandom_range(0, 1));
                3:       ring_in = ~ring_in;
                default: ring_in = 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rises seen by the counter during gate cycles k+1+SETTLE .. k+SETTLE+g.
    function automatic int model_rises(int k, int g);
        int n;
        n = 0;
        for (int m = k + 1 + SETTLE; m <= k + SETTLE + g; m++)
            if (rhist[m - SYNC] === 1'b1 && rhist[m - SYNC - 1] === 1'b0) n++;
        return n;
    endfunction

    // One measurement: abort_into < 0 means no abort; restart_mid pulses start mid-gate.
    task automatic run_meas(input string tag, input logic [GW-1:0] g,
                            input int abort_into, input bit restart_mid);
        int k, geff, t_drain, t_idle, n;
        bit aborted;
        @(negedge clk);
        k        = cyc;
        gate_len = g;
        start    = 1'b1;
        abort    = 1'b0;
        geff     = (g == 0) ? 1 : int'(g);
        aborted  = (abort_into >= 0);
        t_drain  = aborted ? k + 2 + SETTLE + abort_into : k + 1 + SETTLE + geff;
        t_idle   = t_drain + SYNC + 1 + (aborted ? 0 : 1);
        for (int c = k + 1; c <= t_idle; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (c == k + 1) gate_len = 16'($urandom);
            chk($sformatf("%s.ring_en@%0d", tag, c - k), 32'(ring_en), 32'(c < t_drain));
            chk($sformatf("%s.busy@%0d", tag, c - k), 32'(busy), 32'(c < t_idle));
            chk($sformatf("%s.done@%0d", tag, c - k), 32'(done),
                32'(!aborted && c == t_idle - 1));
            if (aborted && c == k + 1 + SETTLE + abort_into) abort = 1'b1;
            if (restart_mid && c == k + 1 + SETTLE + geff / 2) begin
                start    = 1'b1;
                gate_len = 16'd3;
            end
        end
        if (!aborted) begin
            n       = model_rises(k, geff);
            exp_res = (n > CMAX) ? CMAX : n;
            exp_ovf = (n > CMAX) ? 1 : 0;
        end
        chk({tag, ".result_count"}, 32'(result_count), 32'(exp_res));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        int k, n_done, g, a;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        gate_len = '0;
        ring_mode = 3;

        // Reset held three edges with the ring toggling, then one cycle after release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            else if (i == 2) rst = 1'b0;
            chk($sformatf("rst%0d.ring_en", i), 32'(ring_en), 32'(0));
            chk($sformatf("rst%0d.busy", i), 32'(busy), 32'(0));
            chk($sformatf("rst%0d.done", i), 32'(done), 32'(0));
            chk($sformatf("rst%0d.result", i), 32'(result_count), 32'(0));
            chk($sformatf("rst%0d.overflow", i), 32'(overflow), 32'(0));
        end
        ring_mode = 0;
        repeat (4) @(negedge clk);

        // Nominal: period 8, gate 80 -> ten rises.
        ring_mode   = 1;
        ring_period = 8;
        run_meas("nominal", 16'd80, -1, 1'b0);
        chk("nominal.count_const", 32'(result_count), 32'd10);
        chk("nominal.ovf_const", 32'(overflow), 32'd0);

        // Saturation with a fast ring, then a short clean run.
        ring_period = 2;
        run_meas("sat", 16'd64, -1, 1'b0);
        chk("sat.count_const", 32'(result_count), 32'd15);
        chk("sat.ovf_const", 32'(overflow), 32'd1);
        ring_period = 8;
        run_meas("post_sat", 16'd8, -1, 1'b0);
        chk("post_sat.count_const", 32'(result_count), 32'd1);
        chk("post_sat.ovf_const", 32'(overflow), 32'd0);

        // Zero gate behaves as one cycle.
        run_meas("gate0", 16'd0, -1, 1'b0);

        // Abort 20 cycles into an 80-cycle gate.
        run_meas("abort", 16'd80, 20, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("abort.idle_busy", 32'(busy), 32'(0));
            chk("abort.idle_done", 32'(done), 32'(0));
        end

        // Abort and start together in IDLE: abort wins.
        @(negedge clk);
        start    = 1'b1;
        abort    = 1'b1;
        gate_len = 16'd20;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start.busy", 32'(busy), 32'(0));
        chk("abort_start.ring_en", 32'(ring_en), 32'(0));
        @(negedge clk);
        chk("abort_start.busy2", 32'(busy), 32'(0));

        // Start while measuring is ignored; exactly one done.
        run_meas("busy_start", 16'd40, -1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("busy_start.idle_busy", 32'(busy), 32'(0));
            chk("busy_start.idle_done", 32'(done), 32'(0));
        end

        // Randomized runs with a random ring waveform.
        ring_mode = 2;
        for (int r = 0; r < 12; r++) begin
            g = $urandom_range(0, 40);
            a = -1;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, (g == 0) ? 0 : g - 1);
            run_meas($sformatf("rand%0d", r), 16'(g), a, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a measurement.
        ring_mode   = 1;
        ring_period = 8;
        @(negedge clk);
        k        = cyc;
        gate_len = 16'd80;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 10) @(negedge clk);
        chk("rst_mid.busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.ring_en", 32'(ring_en), 32'(0));
        chk("rst_mid.busy", 32'(busy), 32'(0));
        chk("rst_mid.done", 32'(done), 32'(0));
        chk("rst_mid.result", 32'(result_count), 32'(0));
        chk("rst_mid.overflow", 32'(overflow), 32'(0));
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("rst_mid.no_done", 32'(n_done), 32'(0));
        chk("rst_mid.idle_busy", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
